// File: rtl/seg_digit_scan_pkg.sv
// Shared types and constants for the four-digit BCD counter / display scanner.
//   db_state_t      : pushbutton debounce FSM states
//   NDIG, BCD_MAX   : digit count and largest legal BCD digit
//   SEL_RST         : active-low digit select presented out of reset (ones digit)
//   sel_onehot_n()  : active-low one-hot select for a scan index
package seg_digit_scan_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    localparam int         NDIG    = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] SEL_RST = 4'b1110;

    function automatic logic [3:0] sel_onehot_n(input logic [1:0] idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/seg_digit_scan_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser followed by a four-state
// debounce FSM with an 8-bit stability timer.
//   clk, rst_n : system clock, async active-low reset
//   btn        : raw asynchronous button input
//   level      : debounced level (reflects the state being entered this cycle)
//   rise       : single-cycle event on the accepted low-to-high change
module btn_debounce
    import seg_digit_scan_pkg::*;
#(
    parameter int DEBOUNCE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam logic [7:0] TMAX = 8'(DEBOUNCE - 1);

    logic [1:0] sync_r;
    logic       synced_s;
    db_state_t  state_r, state_s;
    logic [7:0] timer_r, timer_s;

    assign synced_s = sync_r[1];

    // Synchroniser, state and timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r  <= 2'b00;
            state_r <= IDLE_LO;
            timer_r <= 8'd0;
        end else begin
            sync_r  <= {sync_r[0], btn};
            state_r <= state_s;
            timer_r <= timer_s;
        end
    end

    // Next-state: a level change is accepted only after DEBOUNCE consecutive
    // synced samples at the new level; any bounce back restarts from idle.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        rise    = 1'b0;
        case (state_r)
            IDLE_LO: begin
                if (synced_s) begin
                    state_s = WAIT_HI;
                    timer_s = 8'd1;
                end else begin
                    state_s = IDLE_LO;
                end
            end
            WAIT_HI: begin
                if (!synced_s) begin
                    state_s = IDLE_LO;
                end else if (timer_r == TMAX) begin
                    state_s = IDLE_HI;
                    rise    = 1'b1;
                end else begin
                    timer_s = timer_r + 8'd1;
                end
            end
            IDLE_HI: begin
                if (!synced_s) begin
                    state_s = WAIT_LO;
                    timer_s = 8'd1;
                end else begin
                    state_s = IDLE_HI;
                end
            end
            WAIT_LO: begin
                if (synced_s) begin
                    state_s = IDLE_HI;
                end else if (timer_r == TMAX) begin
                    state_s = IDLE_LO;
                end else begin
                    timer_s = timer_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE_LO;
                timer_s = 8'd0;
            end
        endcase
    end

    // Level follows the state being entered, so it is already high on the
    // cycle that rise fires.
    assign level = (state_s == IDLE_HI) || (state_s == WAIT_LO);

endmodule

// File: rtl/seg_digit_scan.sv
// Four-digit BCD event counter with debounced increment button, level clear,
// and time-multiplexed display scan with leading-zero blanking.
//   clk, rst_n : system clock, async active-low reset
//   btn_inc    : raw pushbutton, each debounced press adds one
//   btn_clr    : raw level-sensitive clear (synchronised only)
//   nib        : BCD value of the digit being scanned (to 7-seg decoder)
//   digit_sel  : active-low one-hot digit enable, 4'b1111 for a blanked slot
//   wrap       : one-cycle pulse after the count rolls 9999 -> 0000
//   count      : packed BCD count, [15:12] thousands .. [3:0] ones
module seg_digit_scan
    import seg_digit_scan_pkg::*;
#(
    parameter int DEBOUNCE = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_inc,
    input  logic        btn_clr,
    output logic [3:0]  nib,
    output logic [3:0]  digit_sel,
    output logic        wrap,
    output logic [15:0] count
);

    localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);

    logic        inc_level_s, inc_rise_s, inc_evt_s;
    logic [1:0]  clr_sync_r;
    logic        clr_s;
    logic [15:0] count_r, count_s, cnt_inc_s;
    logic        roll_s, wrap_r, wrap_s;
    logic [15:0] pre_r, pre_s;
    logic [1:0]  idx_r, idx_s;
    logic [3:0]  nib_r, nib_s, sel_r, sel_s;
    logic        blank_s;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_inc),
        .level (inc_level_s),
        .rise  (inc_rise_s)
    );

    // A press counts only when the debounced level is actually going high.
    assign inc_evt_s = inc_rise_s & inc_level_s;
    assign clr_s     = clr_sync_r[1];

    // BCD ripple increment; roll_s is the carry out of the thousands digit.
    always_comb begin : bcd_increment
        logic       carry_v;
        logic [3:0] dig_v;
        carry_v   = 1'b1;
        cnt_inc_s = count_r;
        for (int i = 0; i < NDIG; i++) begin
            dig_v = count_r[4*i +: 4];
            if (carry_v) begin
                if (dig_v >= BCD_MAX) begin
                    cnt_inc_s[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc_s[4*i +: 4] = dig_v + 4'd1;
                    carry_v             = 1'b0;
                end
            end else begin
                cnt_inc_s[4*i +: 4] = dig_v;
            end
        end
        roll_s = carry_v;
    end

    // Count update: clear wins over an increment and swallows its wrap.
    always_comb begin
        count_s = count_r;
        wrap_s  = 1'b0;
        if (clr_s) begin
            count_s = 16'h0000;
            wrap_s  = 1'b0;
        end else if (inc_evt_s) begin
            count_s = cnt_inc_s;
            wrap_s  = roll_s;
        end else begin
            count_s = count_r;
            wrap_s  = 1'b0;
        end
    end

    // Scan prescaler, index, and the digit/select values for the next slot.
    always_comb begin
        if (pre_r == PRE_MAX) begin
            pre_s = 16'd0;
            idx_s = idx_r + 2'd1;
        end else begin
            pre_s = pre_r + 16'd1;
            idx_s = idx_r;
        end
        nib_s = count_r[{idx_s, 2'b00} +: 4];
        case (idx_s)
            2'd1:    blank_s = (count_r[15:4]  == 12'd0);
            2'd2:    blank_s = (count_r[15:8]  == 8'd0);
            2'd3:    blank_s = (count_r[15:12] == 4'd0);
            default: blank_s = 1'b0;
        endcase
        if (blank_s) begin
            sel_s = 4'b1111;
        end else begin
            sel_s = sel_onehot_n(idx_s);
        end
    end

    // Clear synchroniser, counter, wrap pulse and scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_sync_r <= 2'b00;
            count_r    <= 16'h0000;
            wrap_r     <= 1'b0;
            pre_r      <= 16'd0;
            idx_r      <= 2'd0;
            nib_r      <= 4'd0;
            sel_r      <= SEL_RST;
        end else begin
            clr_sync_r <= {clr_sync_r[0], btn_clr};
            count_r    <= count_s;
            wrap_r     <= wrap_s;
            pre_r      <= pre_s;
            idx_r      <= idx_s;
            nib_r      <= nib_s;
            sel_r      <= sel_s;
        end
    end

    assign count     = count_r;
    assign wrap      = wrap_r;
    assign nib       = nib_r;
    assign digit_sel = sel_r;

endmodule
